// File: rtl/bingo_guess_turn_ctrl_pkg.sv
// Shared constants for the Bingo guess/turn controller.
//  - NUMW / PIDW : widths of a guessed number and of a turn index
//  - MSG_*       : interboard message codes, mirroring message_macro.v
//  - gt_state_e  : guess FSM states
//  - bcd_to_bin  : two-digit BCD to binary
package bingo_guess_turn_ctrl_pkg;

  localparam int unsigned NUMW = 7;
  localparam int unsigned PIDW = 2;

  // Must stay in step with SEL_NUM / STATE_WIN in message_macro.v.
  localparam logic [2:0] MSG_SEL_NUM   = 3'd1;
  localparam logic [2:0] MSG_STATE_WIN = 3'd4;

  typedef enum logic [1:0] {
    GT_IDLE   = 2'd0,
    GT_WAIT_L = 2'd1,
    GT_WAIT_R = 2'd2,
    GT_FIN    = 2'd3
  } gt_state_e;

  // Non-BCD digits are screened separately by the caller.
  function automatic logic [NUMW-1:0] bcd_to_bin(input logic [7:0] bcd);
    return NUMW'(bcd[7:4]) * NUMW'(10) + NUMW'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/bingo_line_counter.sv
// Counts completed lines (rows, columns, both diagonals) of a GRID x GRID circle mask.
// Cell (r, c) is bit r*GRID + c. The count is registered and saturates at 15.
// Ports:
//  clk          clock
//  rst          synchronous, active-high reset
//  circle_i     circled-cell mask
//  lines_done_o registered count of complete lines
module bingo_line_counter #(
  parameter  int unsigned GRID  = 5,
  localparam int unsigned CELLS = GRID * GRID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CELLS-1:0] circle_i,
  output logic [3:0]       lines_done_o
);

  logic [3:0]  lines_d, lines_q;
  int unsigned cnt;
  logic        row_full, col_full, diag_full, anti_full;

  always_comb begin
    cnt       = 0;
    diag_full = 1'b1;
    anti_full = 1'b1;
    for (int r = 0; r < GRID; r++) begin
      row_full = 1'b1;
      col_full = 1'b1;
      for (int c = 0; c < GRID; c++) begin
        row_full = row_full & circle_i[r*GRID+c];
        col_full = col_full & circle_i[c*GRID+r];
      end
      if (row_full) cnt++;
      if (col_full) cnt++;
      diag_full = diag_full & circle_i[r*GRID+r];
      anti_full = anti_full & circle_i[r*GRID+(GRID-1-r)];
    end
    if (diag_full) cnt++;
    if (anti_full) cnt++;
    // 9x9 boards can have 20 lines; 4 bits saturate.
    lines_d = (cnt > 15) ? 4'd15 : 4'(cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) lines_q <= '0;
    else     lines_q <= lines_d;
  end

  assign lines_done_o = lines_q;

endmodule

// File: rtl/bingo_guess_turn_ctrl.sv
// Guess handler for an N-player GRID x GRID Bingo match: owns the turn pointer, validates the
// local BCD entry (own turn) or remote SEL_NUM (other turns), circles the cell, skips stalled turns.
// Optional feature macro: GUESS_LINE_COUNT_EN enables lines_done/bingo via bingo_line_counter.
// Ports:
//  clk, rst / interboard_rst_i   clock, synchronous active-high resets (same effect)
//  start_guess_i                 arms one turn (IDLE only)
//  clear_guess_i                 clears circle; beats a same-cycle circle set
//  enter_pulse_i, cur_number_bcd_i   local confirm and two-digit BCD entry
//  interboard_*_i                remote message: valid, type, number, sender
//  num_to_pos_i                  slot n-1 holds the cell index of number n
//  guess_done_o / guess_reject_o / turn_timeout_o   one-cycle pulses
//  guess_number_o                last accepted number
//  turn_player_o, circle_o       turn pointer, circled-cell mask
//  lines_done_o, bingo_o         line count and win flag (0 without the macro)
module bingo_guess_turn_ctrl
  import bingo_guess_turn_ctrl_pkg::*;
#(
  parameter  int unsigned GRID        = 5,
  parameter  int unsigned NUM_PLAYERS = 2,
  parameter  int unsigned LOCAL_ID    = 0,
  parameter  int unsigned TIMEOUT_CYC = 0,
  parameter  int unsigned WIN_LINES   = 5,
  localparam int unsigned CELLS       = GRID * GRID,
  localparam int unsigned POSW        = $clog2(CELLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  interboard_rst_i,
  input  logic                  start_guess_i,
  input  logic                  clear_guess_i,
  input  logic                  enter_pulse_i,
  input  logic [7:0]            cur_number_bcd_i,
  input  logic                  interboard_en_i,
  input  logic [2:0]            interboard_msg_type_i,
  input  logic [NUMW-1:0]       interboard_number_i,
  input  logic [PIDW-1:0]       interboard_player_i,
  input  logic [CELLS*POSW-1:0] num_to_pos_i,
  output logic                  guess_done_o,
  output logic [NUMW-1:0]       guess_number_o,
  output logic                  guess_reject_o,
  output logic                  turn_timeout_o,
  output logic [PIDW-1:0]       turn_player_o,
  output logic [CELLS-1:0]      circle_o,
  output logic [3:0]            lines_done_o,
  output logic                  bingo_o
);

  localparam logic [NUMW-1:0] CellsN   = NUMW'(CELLS);
  localparam logic [PIDW-1:0] LastPid  = PIDW'(NUM_PLAYERS - 1);
  localparam logic [PIDW-1:0] LocalPid = PIDW'(LOCAL_ID);
  localparam logic [31:0]     TmoLast  = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

  gt_state_e        state_q;
  logic [PIDW-1:0]  turn_q;
  logic [CELLS-1:0] circle_q;
  logic [NUMW-1:0]  guess_number_q;
  logic             guess_done_q, guess_reject_q, turn_timeout_q;
  logic [31:0]      tmr_q;

  logic [NUMW-1:0]  num, num_idx;
  logic [POSW-1:0]  pos;
  logic             bcd_ok, num_ok, sel_turn, win_msg, accept, bad, tmo_hit;
  logic [PIDW-1:0]  next_turn;

  always_comb begin
    bcd_ok  = (cur_number_bcd_i[7:4] <= 4'd9) && (cur_number_bcd_i[3:0] <= 4'd9);
    num     = (state_q == GT_WAIT_L) ? bcd_to_bin(cur_number_bcd_i) : interboard_number_i;
    num_ok  = (num != '0) && (num <= CellsN);
    num_idx = num_ok ? num - NUMW'(1) : '0;
    pos     = num_to_pos_i[32'(num_idx)*POSW +: POSW];
    // A map entry outside the board or an already circled cell is as bad as a wrong number.
    if ((32'(pos) >= CELLS) || circle_q[pos]) num_ok = 1'b0;
    if ((state_q == GT_WAIT_L) && !bcd_ok) num_ok = 1'b0;

    win_msg  = interboard_en_i && (interboard_msg_type_i == MSG_STATE_WIN);
    sel_turn = interboard_en_i && (interboard_msg_type_i == MSG_SEL_NUM) &&
               (interboard_player_i == turn_q);
    accept   = (((state_q == GT_WAIT_L) && enter_pulse_i) ||
                ((state_q == GT_WAIT_R) && sel_turn)) && num_ok;
    bad      = (((state_q == GT_WAIT_L) && enter_pulse_i) ||
                ((state_q == GT_WAIT_R) && sel_turn)) && !num_ok;
    tmo_hit  = (TIMEOUT_CYC != 0) && (tmr_q == TmoLast);
    next_turn = (turn_q == LastPid) ? '0 : turn_q + PIDW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || interboard_rst_i) begin
      state_q        <= GT_IDLE;
      turn_q         <= '0;
      circle_q       <= '0;
      guess_number_q <= '0;
      guess_done_q   <= 1'b0;
      guess_reject_q <= 1'b0;
      turn_timeout_q <= 1'b0;
      tmr_q          <= '0;
    end else begin
      guess_done_q   <= 1'b0;
      guess_reject_q <= 1'b0;
      turn_timeout_q <= 1'b0;
      if (clear_guess_i) circle_q <= '0;

      unique case (state_q)
        GT_IDLE: begin
          if (start_guess_i) begin
            tmr_q   <= '0;
            state_q <= (turn_q == LocalPid) ? GT_WAIT_L : GT_WAIT_R;
          end
        end
        GT_WAIT_L, GT_WAIT_R: begin
          if (win_msg) begin
            state_q <= GT_IDLE;
          end else if (accept) begin
            if (!clear_guess_i) circle_q[pos] <= 1'b1;
            guess_number_q <= num;
            state_q        <= GT_FIN;
          end else begin
            guess_reject_q <= bad;
            if (tmo_hit) begin
              turn_timeout_q <= 1'b1;
              turn_q         <= next_turn;
              state_q        <= GT_IDLE;
            end else begin
              tmr_q <= tmr_q + 32'd1;
            end
          end
        end
        GT_FIN: begin
          guess_done_q <= 1'b1;
          turn_q       <= next_turn;
          state_q      <= GT_IDLE;
        end
        default: state_q <= GT_IDLE;
      endcase
    end
  end

  assign guess_done_o   = guess_done_q;
  assign guess_number_o = guess_number_q;
  assign guess_reject_o = guess_reject_q;
  assign turn_timeout_o = turn_timeout_q;
  assign turn_player_o  = turn_q;
  assign circle_o       = circle_q;

`ifdef GUESS_LINE_COUNT_EN
  localparam bit LineCntEn = 1'b1;
  logic rst_any;
  assign rst_any = rst | interboard_rst_i;

  bingo_line_counter #(
    .GRID (GRID)
  ) u_line_counter (
    .clk          (clk),
    .rst          (rst_any),
    .circle_i     (circle_q),
    .lines_done_o (lines_done_o)
  );
`else
  localparam bit LineCntEn = 1'b0;
  assign lines_done_o = '0;
`endif

  // Folds to a constant 0 when line counting is compiled out.
  assign bingo_o = LineCntEn && (32'(lines_done_o) >= WIN_LINES);

endmodule
